// File: rtl/fft_frame_ctrl.sv
// FFT frame sequencer: captures one sop..eop frame, feeds cefu, re-aligns
// its delayed output with bin indices, writes the spectrum and tracks the peak.
module fft_frame_ctrl #(
    parameter int N_POINTS = 1024,
    parameter int IDX_W    = 10,
    parameter int PIPE_LAT = 4,
    parameter int SKIP_DC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    input  logic             fft_valid,
    input  logic             fft_sop,
    input  logic             fft_eop,
    input  logic [17:0]      fft_q,
    input  logic [5:0]       fft_exp,
    output logic             fft_ready,
    output logic [17:0]      cefu_q_sig,
    output logic [5:0]       cefu_exp,
    input  logic [19:0]      cefu_v_data,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_addr,
    output logic [19:0]      wr_data,
    output logic [IDX_W-1:0] peak_bin,
    output logic [19:0]      peak_val,
    output logic             frame_done,
    output logic             frame_err
);

    typedef enum logic [2:0] {IDLE, ARM, STREAM, DRAIN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
    localparam logic [IDX_W-1:0] SKIP_IDX = IDX_W'(SKIP_DC);

    state_t state, state_nxt;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] beat_idx;
    logic             accept;
    logic             frame_beat;
    logic             last_beat;
    logic             beat_err;
    logic             pending;

    // Stage 0 lines up with cefu_q_sig, stage PIPE_LAT with cefu_v_data.
    logic [PIPE_LAT:0] dv;
    logic [IDX_W-1:0]  di [PIPE_LAT+1];

    logic [19:0]      wmax;
    logic [IDX_W-1:0] wbin;

    assign accept     = fft_valid & fft_ready;
    assign frame_beat = accept & ((state == STREAM) | ((state == ARM) & fft_sop));
    assign beat_idx   = (state == ARM) ? '0 : idx;
    assign last_beat  = fft_eop | (beat_idx == LAST_IDX);
    assign beat_err   = (fft_eop & (beat_idx != LAST_IDX))
                      | (~fft_eop & (beat_idx == LAST_IDX))
                      | (fft_sop & (state == STREAM));
    assign pending    = |dv[PIPE_LAT-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = ARM;
            ARM:    if (frame_beat) state_nxt = last_beat ? DRAIN : STREAM;
            STREAM: if (frame_beat && last_beat) state_nxt = DRAIN;
            DRAIN:  if (!pending) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fft_ready  = (state == ARM) | (state == STREAM);
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            cefu_q_sig <= '0;
            cefu_exp   <= '0;
            frame_err  <= 1'b0;
            dv         <= '0;
            for (int i = 0; i <= PIPE_LAT; i++) di[i] <= '0;
        end else begin
            dv    <= {dv[PIPE_LAT-1:0], frame_beat};
            di[0] <= beat_idx;
            for (int i = 1; i <= PIPE_LAT; i++) di[i] <= di[i-1];
            if (frame_beat) begin
                idx        <= beat_idx + 1'b1;
                cefu_q_sig <= fft_q;
                cefu_exp   <= fft_exp;
            end
            if (state == IDLE && start)
                frame_err <= 1'b0;
            else if (frame_beat && beat_err)
                frame_err <= 1'b1;
        end
    end

    // Strict greater-than keeps the lowest bin on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wmax     <= '0;
            wbin     <= '0;
            peak_bin <= '0;
            peak_val <= '0;
        end else begin
            if (frame_beat && state == ARM) begin
                wmax <= '0;
                wbin <= '0;
            end else if (dv[PIPE_LAT] && di[PIPE_LAT] >= SKIP_IDX
                         && cefu_v_data > wmax) begin
                wmax <= cefu_v_data;
                wbin <= di[PIPE_LAT];
            end
            if (state == DONE) begin
                peak_bin <= wbin;
                peak_val <= wmax;
            end
        end
    end

    assign wr_en   = dv[PIPE_LAT];
    assign wr_addr = dv[PIPE_LAT] ? di[PIPE_LAT] : '0;
    assign wr_data = dv[PIPE_LAT] ? cefu_v_data : '0;

endmodule
